seven_seg_scan: RTL and testbench
=================================

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000, meaning clock cycles per digit slot (1 kHz digit rate at 100 MHz).
REQ-002 Parameter BLINK_DIV, default 25000000, meaning clock cycles per blink-phase toggle (2 Hz blink at 100 MHz).
REQ-003 clk  input  1  system clock, rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 min_tens, min_ones, sec_tens, sec_ones  input  4 each  BCD digits from stopwatch.
REQ-006 ADJ  input  1  adjust mode active; selected digit pair blinks.
REQ-007 SEL  input  1  pair select: 0 = minutes (digits 3,2), 1 = seconds (digits 1,0).
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 an  output  4  digit enables, active-low; an[0] = sec_ones … an[3] = min_tens.
REQ-010 dp  output  1  decimal point, active-low.

Function
REQ-011 Refresh counter SHALL count 0..SCAN_DIV-1 and wrap to 0.
REQ-012 Digit index (2 bits) SHALL advance 0→1→2→3→0 on the edge where the refresh counter equals SCAN_DIV-1.
REQ-013 seg, an, dp SHALL be registered; they reflect the current index and inputs with one-cycle latency.
REQ-014 Exactly one an bit SHALL be low when not blanked: an = ~(4'b0001 << index).
REQ-015 Digit source: index 0 sec_ones, 1 sec_tens, 2 min_ones, 3 min_tens.
REQ-016 BCD 0–9 SHALL decode to standard patterns (0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000); codes 10–15 SHALL give seg = 7'b1111111.
REQ-017 dp SHALL be 0 only while index = 2 (minutes/seconds separator), else 1.
REQ-018 Blink counter SHALL count 0..BLINK_DIV-1 and toggle blink_phase at wrap, only while ADJ = 1.
REQ-019 While ADJ = 0, blink counter and blink_phase SHALL be held at 0, so entering adjust mode starts visible.
REQ-020 Blanking: when ADJ = 1, blink_phase = 1 and index belongs to the SEL pair, an SHALL be 4'b1111, seg 7'b1111111, dp 1.
REQ-021 SEL or ADJ change SHALL affect outputs on the next cycle; scan timing unaffected.
REQ-022 Input digits SHALL be sampled every cycle (no snapshot); changes mid-slot appear next cycle.

Reset
REQ-023 RESET = 1 SHALL immediately clear refresh counter, index, blink counter, blink_phase.
REQ-024 During reset outputs SHALL be an = 4'b1111, seg = 7'b1111111, dp = 1.
REQ-025 First rising edge after RESET falls SHALL produce an = 4'b1110 showing sec_ones.
REQ-026 Reset asserted mid-slot or mid-blank SHALL abort the scan with no glitch beyond the blank value.

Structure
REQ-027 Package stopwatch_pkg SHALL hold the segment pattern constants (digits 0–9, SEG_BLANK) and digit-index constants.
REQ-028 Combinational sub-module seg7_decode (4-bit BCD in, 7-bit seg out) SHALL be instantiated once.
REQ-029 Counter widths SHALL be derived from SCAN_DIV and BLINK_DIV via $clog2.

Verification (SCAN_DIV = 4, BLINK_DIV = 16, 10 ns clock)
REQ-030 Reset held, then released with digits 1,2,3,4 (min_tens..sec_ones) -> an sequence 1110,1101,1011,0111 each 4 cycles; seg 4,3,2,1 patterns; dp = 0 only with an = 1011.
REQ-031 RESET pulsed while an = 1011 -> outputs immediately blank, restart at an = 1110 after release.
REQ-032 ADJ = 1, SEL = 1 -> digits 0,1 visible 16 cycles, blanked 16 cycles, alternating; digits 2,3 never blanked.
REQ-033 ADJ = 1, SEL = 0 in blank phase, ADJ dropped -> minutes visible next cycle; ADJ reasserted -> visible for full 16 cycles first.
REQ-034 sec_ones = 4'hA -> seg = 7'b1111111 while an = 1110; other digits unaffected.
REQ-035 sec_ones changed 5→6 mid-slot while an = 1110 -> seg shows 6 the following cycle, index timing unchanged.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: active-low segment patterns
// ({g,f,e,d,c,b,a}) and the digit-slot indices used by the scanner.
package stopwatch_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_BLANK  = 4'b1111;

  // Slot order matches the anode numbering: slot n drives an[n].
  typedef enum logic [1:0] {
    DIG_SEC_ONES = 2'd0,
    DIG_SEC_TENS = 2'd1,
    DIG_MIN_ONES = 2'd2,
    DIG_MIN_TENS = 2'd3
  } digit_idx_e;

  // Width of a counter holding 0..div-1; never below one bit.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment decoder; non-decimal codes 10-15 go dark.
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: the default arm covers every unlisted code, so seg is always assigned and no latch is inferred.
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver for the stopwatch (MM.SS) with
// adjust-mode blinking of the selected digit pair; all outputs are registered.
module seven_seg_scan
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  input  logic       ADJ,
  input  logic       SEL,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int SCAN_W  = cnt_width(SCAN_DIV);
  localparam int BLINK_W = cnt_width(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  digit_idx_e         idx;

  logic [3:0] digit;
  logic [6:0] digit_seg;
  logic       blank;

  // Refresh counter and digit index.
  always_ff @(posedge clk or posedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RESET) begin
      scan_cnt <= '0;
      idx      <= DIG_SEC_ONES;
    end else if (scan_cnt == SCAN_MAX) begin
      scan_cnt <= '0;
      idx      <= digit_idx_e'(idx + 2'd1);
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Blink timebase runs only in adjust mode and restarts visible on entry.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!ADJ) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    digit = sec_ones;
    case (idx)
      DIG_SEC_ONES: digit = sec_ones;
      DIG_SEC_TENS: digit = sec_tens;
      DIG_MIN_ONES: digit = min_ones;
      DIG_MIN_TENS: digit = min_tens;
      default:      digit = sec_ones;
    endcase
  end

  seg7_decode u_decode (
    .bcd (digit),
    .seg (digit_seg)
  );

  // idx[1] is 0 for the seconds pair and 1 for the minutes pair; SEL=1 picks seconds.
  assign blank = ADJ && blink_phase && (idx[1] == ~SEL);

  // Output register: resets dark so the display never flashes a stale digit.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      seg <= SEG_BLANK;
      an  <= AN_BLANK;
      dp  <= 1'b1;
    end else if (blank) begin
      seg <= SEG_BLANK;
      an  <= AN_BLANK;
      dp  <= 1'b1;
    end else begin
      seg <= digit_seg;
      an  <= ~(4'b0001 << idx);
      dp  <= (idx != DIG_MIN_ONES);
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with SCAN_DIV=4, BLINK_DIV=16, 10 ns clock.
module tb_seven_seg_scan;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] min_tens = 4'd1;
  logic [3:0] min_ones = 4'd2;
  logic [3:0] sec_tens = 4'd3;
  logic [3:0] sec_ones = 4'd4;
  logic       ADJ = 1'b0;
  logic       SEL = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;   // rising edges since reset release
  int adj_start = 0; // cyc value at which ADJ was last raised

  seven_seg_scan #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clk      (clk),
    .RESET    (RESET),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .ADJ      (ADJ),
    .SEL      (SEL),
    .seg      (seg),
    .an       (an),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Slot shown after edge k was active during the cycle before it.
  function automatic int exp_idx(input int k);
    return ((k - 1) / 4) % 4;
  endfunction

  function automatic bit exp_blank(input int k);
    int i;
    i = exp_idx(k);
    if (!ADJ || k <= adj_start) return 1'b0;
    if ((((k - 1 - adj_start) / 16) % 2) != 1) return 1'b0;
    return SEL ? (i < 2) : (i >= 2);
  endfunction

  function automatic logic [3:0] exp_an(input int k);
    logic [3:0] one;
    one = 4'b0001;
    if (exp_blank(k)) return 4'b1111;
    return ~(one << exp_idx(k));
  endfunction

  function automatic logic [6:0] exp_seg(input int k);
    if (exp_blank(k)) return 7'b1111111;
    case (exp_idx(k))
      0: return pat(sec_ones);
      1: return pat(sec_tens);
      2: return pat(min_ones);
      default: return pat(min_tens);
    endcase
  endfunction

  function automatic logic exp_dp(input int k);
    return (!exp_blank(k) && exp_idx(k) == 2) ? 1'b0 : 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    RESET = 1'b0;
    cyc = 0;
  endtask

  task automatic check_all(input string name);
    total++;
    if (an !== exp_an(cyc) || seg !== exp_seg(cyc) || dp !== exp_dp(cyc))
      $display("FAIL %s cyc=%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               name, cyc, an, seg, dp, exp_an(cyc), exp_seg(cyc), exp_dp(cyc));
    else passed++;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1)
      $display("FAIL reset_outputs: an=%b seg=%b dp=%b, expected 1111 1111111 1", an, seg, dp);
    else passed++;
  endtask

  task automatic test_scan();
    {min_tens, min_ones, sec_tens, sec_ones} = {4'd1, 4'd2, 4'd3, 4'd4};
    do_reset();
    tick();
    total++;
    if (an !== 4'b1110 || seg !== 7'b0011001)
      $display("FAIL first_edge: an=%b seg=%b, expected 1110 0011001", an, seg);
    else passed++;
    for (int k = 2; k <= 17; k++) begin
      tick();
      check_all("scan");
    end
  endtask

  task automatic test_reset_midslot();
    do_reset();
    while (cyc < 10) tick();
    total++;
    if (an !== 4'b1011 || dp !== 1'b0)
      $display("FAIL pre_reset_slot: an=%b dp=%b, expected 1011 0", an, dp);
    else passed++;
    #2 RESET = 1'b1;
    #1;
    total++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1)
      $display("FAIL async_reset: an=%b seg=%b dp=%b, expected 1111 1111111 1", an, seg, dp);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    RESET = 1'b0;
    cyc = 0;
    tick();
    total++;
    if (an !== 4'b1110 || seg !== 7'b0011001)
      $display("FAIL restart: an=%b seg=%b, expected 1110 0011001", an, seg);
    else passed++;
  endtask

  task automatic test_blink_sec();
    do_reset();
    ADJ = 1'b1;
    SEL = 1'b1;
    adj_start = 0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      check_all("blink_sec");
    end
    total++;
    if (an !== 4'b1110 && cyc != 64)
      $display("FAIL blink_sec_end: cyc=%0d, expected 64", cyc);
    else passed++;
    ADJ = 1'b0;
    SEL = 1'b0;
  endtask

  task automatic test_adj_drop();
    do_reset();
    ADJ = 1'b1;
    SEL = 1'b0;
    adj_start = 0;
    while (cyc < 26) tick();
    total++;
    if (an !== 4'b1111 || seg !== 7'b1111111)
      $display("FAIL min_blanked: an=%b seg=%b, expected 1111 1111111", an, seg);
    else passed++;
    ADJ = 1'b0;
    tick();
    total++;
    if (an !== 4'b1011 || seg !== 7'b0100100 || dp !== 1'b0)
      $display("FAIL adj_drop_visible: an=%b seg=%b dp=%b, expected 1011 0100100 0", an, seg, dp);
    else passed++;
    tick();
    ADJ = 1'b1;
    adj_start = cyc;
    for (int k = 0; k < 17; k++) begin
      tick();
      check_all("adj_reenter");
    end
    total++;
    if (an !== 4'b1111)
      $display("FAIL adj_reenter_blank: an=%b, expected 1111 at cyc %0d", an, cyc);
    else passed++;
    ADJ = 1'b0;
  endtask

  task automatic test_invalid_bcd();
    sec_ones = 4'hA;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_all("invalid_bcd");
    end
    total++;
    if (an !== 4'b1101 || seg !== 7'b0110000)
      $display("FAIL invalid_neighbour: an=%b seg=%b, expected 1101 0110000", an, seg);
    else passed++;
  endtask

  task automatic test_midslot_change();
    sec_ones = 4'd5;
    do_reset();
    tick();
    tick();
    total++;
    if (an !== 4'b1110 || seg !== 7'b0010010)
      $display("FAIL shows_5: an=%b seg=%b, expected 1110 0010010", an, seg);
    else passed++;
    sec_ones = 4'd6;
    tick();
    total++;
    if (an !== 4'b1110 || seg !== 7'b0000010)
      $display("FAIL shows_6: an=%b seg=%b, expected 1110 0000010", an, seg);
    else passed++;
    tick();
    total++;
    if (an !== 4'b1110)
      $display("FAIL slot_hold: an=%b, expected 1110", an);
    else passed++;
    tick();
    total++;
    if (an !== 4'b1101 || seg !== 7'b0110000)
      $display("FAIL slot_advance: an=%b seg=%b, expected 1101 0110000", an, seg);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_reset_midslot();
    test_blink_sec();
    test_adj_drop();
    test_invalid_bcd();
    test_midslot_change();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
